// File: rtl/mem_line_bridge.sv
// mem_line_bridge: one-line write-through buffer between the CPU word port (mem_*) and burst memory (pmem_*, 64-bit beats)
module mem_line_bridge #(
  parameter int BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_address,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic [31:0] pmem_address,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [63:0] pmem_wdata,
  input  logic [63:0] pmem_rdata,
  input  logic        pmem_resp
);
  localparam int OFF = $clog2(BURST_LEN * 8);
  localparam int CW = $clog2(BURST_LEN);
  typedef enum logic [2:0] {IDLE, FILL, MERGE, WBACK, RESP} state_t;
  state_t state;
  logic [BURST_LEN-1:0][63:0] line;
  logic [31-OFF:0] tag;
  logic valid;
  logic [CW-1:0] cnt;
  logic [CW-1:0] sel_beat;
  logic sel_half, hit, last, unused;
  assign unused = ^mem_address[1:0];
  assign sel_beat = mem_address[OFF-1:3];
  assign sel_half = mem_address[2];
  assign hit = valid && tag == mem_address[31:OFF];
  assign last = cnt == CW'(BURST_LEN - 1);
  assign mem_rdata = sel_half ? line[sel_beat][63:32] : line[sel_beat][31:0];
  assign mem_resp = state == RESP;
  assign pmem_read = state == FILL;
  assign pmem_write = state == WBACK;
  assign pmem_address = pmem_read ? {mem_address[31:OFF], {OFF{1'b0}}} :
                        pmem_write ? {tag, {OFF{1'b0}}} : '0;
  assign pmem_wdata = pmem_write ? line[cnt] : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      valid <= 1'b0;
      tag <= '0;
      cnt <= '0;
      line <= '0;
    end else begin
      case (state)
        IDLE: if (mem_read || mem_write) begin
          state <= !hit ? FILL : mem_write ? MERGE : RESP;
          cnt <= '0;
        end
        FILL: if (pmem_resp) begin
          line[cnt] <= pmem_rdata;
          cnt <= cnt + 1'b1;
          if (last) begin
            valid <= 1'b1;
            tag <= mem_address[31:OFF];
            state <= mem_write ? MERGE : RESP;
          end
        end
        MERGE: begin
          for (int i = 0; i < 4; i++)
            if (mem_byte_enable[i]) line[sel_beat][{sel_half, i[1:0], 3'b000} +: 8] <= mem_wdata[8*i +: 8];
          cnt <= '0;
          state <= WBACK;
        end
        WBACK: if (pmem_resp) begin
          cnt <= cnt + 1'b1;
          if (last) state <= RESP;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_line_bridge.sv
// tb_mem_line_bridge: directed self-checking bench with a burst-memory slave and a flat write-through memory model
module tb_mem_line_bridge;
  localparam int BL = 4;
  logic clk = 0, rst_n = 0;
  logic [31:0] mem_address = 0, mem_wdata = 0, mem_rdata, pmem_address;
  logic mem_read = 0, mem_write = 0, mem_resp, pmem_read, pmem_write, pmem_resp = 0;
  logic [3:0] mem_byte_enable = 0;
  logic [63:0] pmem_wdata, pmem_rdata = 0;
  logic [63:0] phys [256];
  logic [63:0] ref_m [256];
  logic [63:0] wlog [BL];
  int tests = 0, fails = 0, rbeats = 0, wbeats = 0;
  logic active = 0, cur_wr = 0, gap = 0, mvalid = 0;
  logic [31:0] cur_addr = 0, last_rdata = 0;
  logic [26:0] mtag = 0;
  always #5 clk = ~clk;
  mem_line_bridge #(.BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .pmem_address(pmem_address),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );
  function automatic int bidx(input logic [31:0] a);
    return int'(a[10:3]);
  endfunction
  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [63:0] b;
    b = ref_m[bidx(a)];
    return a[2] ? b[63:32] : b[31:0];
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  initial begin
    int sbeat;
    int b;
    bit phase;
    sbeat = 0;
    phase = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || !(pmem_read || pmem_write)) begin
        pmem_resp = 0;
        sbeat = 0;
        phase = 0;
      end else begin
        if (gap && phase) pmem_resp = 0;
        else begin
          pmem_resp = 1;
          b = int'({pmem_address[10:5], sbeat[1:0]});
          if (pmem_read) begin
            pmem_rdata = phys[b];
            rbeats++;
          end else begin
            phys[b] = pmem_wdata;
            wlog[sbeat] = pmem_wdata;
            wbeats++;
          end
          sbeat = (sbeat + 1) % BL;
        end
        phase = ~phase;
      end
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (rst_n) begin
      chk("rd_wr_exclusive", {63'd0, pmem_read && pmem_write}, 64'd0);
      if (pmem_read || pmem_write) chk("pmem_address", pmem_address, {32'd0, cur_addr[31:5], 5'd0});
      if (mem_resp) begin
        chk("resp_pending", {63'd0, active}, 64'd1);
        if (!cur_wr) chk("mem_rdata", mem_rdata, ref_word(cur_addr));
      end
    end
  end
  task automatic req(input logic [31:0] a, input logic rd, input logic wr, input logic [3:0] be, input logic [31:0] wd);
    bit hit;
    int lat, cyc, base;
    hit = mvalid && mtag == a[31:5];
    lat = 1 + (hit ? 0 : (gap ? 2 * BL - 1 : BL)) + (wr ? 1 + BL : 0);
    base = int'({a[10:5], 2'b00});
    @(negedge clk);
    cur_addr = a;
    cur_wr = wr;
    active = 1;
    rbeats = 0;
    wbeats = 0;
    mem_address = a;
    mem_read = rd;
    mem_write = wr;
    mem_byte_enable = be;
    mem_wdata = wd;
    if (wr) for (int i = 0; i < 4; i++) if (be[i]) ref_m[bidx(a)][32 * a[2] + 8 * i +: 8] = wd[8*i +: 8];
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!mem_resp && cyc < 200);
    last_rdata = mem_rdata;
    chk("latency", cyc, lat);
    @(negedge clk);
    mem_read = 0;
    mem_write = 0;
    active = 0;
    chk("fill_beats", rbeats, hit ? 0 : BL);
    chk("wb_beats", wbeats, wr ? BL : 0);
    if (wr) for (int k = 0; k < BL; k++) chk("wb_beat", wlog[k], ref_m[base + k]);
    mvalid = 1;
    mtag = a[31:5];
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int n;
    for (int i = 0; i < 256; i++) phys[i] = {8{8'(i * 3 + 7)}};
    for (int k = 0; k < BL; k++) phys[32 + k] = {16{4'(k + 1)}};
    for (int i = 0; i < 256; i++) ref_m[i] = phys[i];
    repeat (2) @(negedge clk);
    chk("rst_mem_resp", {63'd0, mem_resp}, 64'd0);
    chk("rst_pmem_read", {63'd0, pmem_read}, 64'd0);
    chk("rst_pmem_write", {63'd0, pmem_write}, 64'd0);
    chk("rst_pmem_address", {32'd0, pmem_address}, 64'd0);
    chk("rst_pmem_wdata", pmem_wdata, 64'd0);
    chk("rst_mem_rdata", {32'd0, mem_rdata}, 64'd0);
    rst_n = 1;
    req(32'h0000_0104, 1, 0, 4'b0000, 32'h0);
    chk("lit_cold_miss", {32'd0, last_rdata}, 64'h1111_1111);
    req(32'h0000_0118, 1, 0, 4'b0000, 32'h0);
    chk("lit_hit", {32'd0, last_rdata}, 64'h4444_4444);
    req(32'h0000_0108, 0, 1, 4'b0011, 32'hDEAD_BEEF);
    chk("lit_wb_beat1", wlog[1], 64'h2222_2222_2222_BEEF);
    chk("lit_wb_beat0", wlog[0], 64'h1111_1111_1111_1111);
    chk("lit_wb_beat3", wlog[3], 64'h4444_4444_4444_4444);
    req(32'h0000_0200, 0, 1, 4'b1111, 32'hCAFE_F00D);
    req(32'h0000_0104, 1, 0, 4'b0000, 32'h0);
    chk("lit_refill", {32'd0, last_rdata}, 64'h1111_1111);
    gap = 1;
    req(32'h0000_0300, 1, 0, 4'b0000, 32'h0);
    gap = 0;
    req(32'h0000_0300, 0, 1, 4'b0000, 32'hFFFF_FFFF);
    req(32'h0000_030C, 1, 1, 4'b1100, 32'h1234_5678);
    req(32'h0000_030C, 1, 0, 4'b0000, 32'h0);
    @(negedge clk);
    cur_addr = 32'h0000_0400;
    cur_wr = 0;
    active = 1;
    rbeats = 0;
    mem_address = 32'h0000_0400;
    mem_read = 1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (rbeats < 2 && n < 50);
    chk("abort_beats", rbeats, 2);
    #1 rst_n = 0;
    #1;
    chk("abort_pmem_read", {63'd0, pmem_read}, 64'd0);
    chk("abort_pmem_address", {32'd0, pmem_address}, 64'd0);
    chk("abort_mem_resp", {63'd0, mem_resp}, 64'd0);
    @(negedge clk);
    mem_read = 0;
    active = 0;
    mvalid = 0;
    @(negedge clk);
    rst_n = 1;
    req(32'h0000_0400, 1, 0, 4'b0000, 32'h0);
    req(32'h0000_0404, 1, 0, 4'b0000, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
